// File: rtl/galpal_pkg.sv
// Shared widths and FSM encoding for the GAL/PAL vector capture block.
`timescale 1ns/1ps
package galpal_pkg;

    localparam int I_W_DEF = 12;
    localparam int O_W_DEF = 10;
    localparam int VEC_W   = I_W_DEF + O_W_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

endpackage

// File: rtl/galpal_sync_fifo.sv
// Synchronous FIFO with a registered head word.
// vec_data-style output holds its last value when the FIFO goes empty.
`timescale 1ns/1ps
module galpal_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign wr_next = wr_ptr + (AW+1)'(push_ok);
    assign rd_next = rd_ptr + (AW+1)'(pop_ok);
    assign dout    = head;

    // Storage array: data only, no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers with an extra wrap bit; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
        end
    end

    // Head register: preloads the next entry, bypassing din when that entry is written now.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (wr_next != rd_next) begin
            if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                head <= din;
            end else begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/galpal_vec_capture.sv
// Captures {stimulus, response} vectors from a GAL/PAL under test after a settle delay.
`timescale 1ns/1ps
module galpal_vec_capture
    import galpal_pkg::*;
#(
    parameter int I_W        = I_W_DEF,
    parameter int O_W        = O_W_DEF,
    parameter int SETTLE_CYC = 21,
    parameter int DEPTH      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [I_W-1:0]     I,
    input  logic [O_W-1:0]     O,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic [I_W+O_W-1:0] vec_data,
    output logic [15:0]        vec_count,
    output logic               overflow,
    output logic               busy
);

    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(SETTLE_CYC - 1);

    logic [I_W-1:0] i_p0;
    logic [I_W-1:0] i_p1;
    logic [I_W-1:0] i_prev;
    logic [O_W-1:0] o_p0;
    logic [O_W-1:0] o_p1;
    logic           change;

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_next;
    logic           capture;

    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    // Two-flop synchronizers for both pin buses plus the previous-cycle stimulus copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_p0   <= '0;
            i_p1   <= '0;
            i_prev <= '0;
            o_p0   <= '0;
            o_p1   <= '0;
        end else begin
            i_p0   <= I;
            i_p1   <= i_p0;
            i_prev <= i_p1;
            o_p0   <= O;
            o_p1   <= o_p0;
        end
    end

    assign change = (i_p1 != i_prev);

    // FSM state and settle timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state logic: restart the settle window on every change, capture when it expires.
    always_comb begin
        state_next = state;
        timer_next = timer;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (en && change) begin
                    state_next = SETTLE;
                    timer_next = TLOAD;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (change) begin
                    timer_next = TLOAD;
                end else if (timer == '0) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign busy      = (state == SETTLE);
    assign pop       = vec_valid && vec_ready;
    assign vec_valid = !fifo_empty;

    // Capture counter (saturating) and sticky overflow for pushes lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_count <= '0;
            overflow  <= 1'b0;
        end else if (capture) begin
            if (vec_count != 16'hFFFF) begin
                vec_count <= vec_count + 16'd1;
            end
            if (fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    galpal_sync_fifo #(
        .WIDTH (I_W + O_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   ({i_p1, o_p1}),
        .full  (fifo_full),
        .pop   (vec_ready),
        .empty (fifo_empty),
        .dout  (vec_data)
    );

endmodule

// File: tb/tb_galpal_vec_capture.sv
// Scoreboard bench for galpal_vec_capture: directed pin changes, queued expected vectors.
`timescale 1ns/1ps
module tb_galpal_vec_capture;

    localparam int IW = 12;
    localparam int OW = 10;
    localparam int S  = 21;
    localparam int D  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic [IW-1:0]  I = '0;
    logic [OW-1:0]  O = '0;
    logic           vec_valid;
    logic           vec_ready = 1'b0;
    logic [IW+OW-1:0] vec_data;
    logic [15:0]    vec_count;
    logic           overflow;
    logic           busy;

    logic [IW+OW-1:0] sb [$];
    int checks = 0;
    int errors = 0;

    galpal_vec_capture #(
        .I_W(IW), .O_W(OW), .SETTLE_CYC(S), .DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .I(I), .O(O),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .vec_count(vec_count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        I   = '0;
        sb.delete();
        step(3);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        vec_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (sb.size() == 0) break;
            step(1);
        end
        step(2);
        chk(name, sb.size(), 0);
        vec_ready = 1'b0;
    endtask

    // Monitor: each accepted head is checked against the oldest expected vector.
    always @(negedge clk) begin
        if (!rst && vec_valid && vec_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vec: got %0h expected none", vec_data);
            end else begin
                if (vec_data !== sb[0]) begin
                    errors++;
                    $display("FAIL vec_data: got %0h expected %0h", vec_data, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        O = 10'h2A5;
        do_reset();
        rst = 1'b1;
        step(1);
        chk("rst_valid", vec_valid, 0);
        chk("rst_data", vec_data, 0);
        chk("rst_count", vec_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step(2);

        // Test 1: single change, exact latency
        vec_ready = 1'b1;
        I = 12'h008;
        sb.push_back({12'h008, O});
        step(S + 2);
        chk("t1_valid_early", vec_valid, 0);
        chk("t1_busy", busy, 1);
        step(1);
        chk("t1_valid_rise", vec_valid, 1);
        chk("t1_busy_done", busy, 0);
        step(S + 5);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_count", vec_count, 1);

        // Test 2: toggling keeps the settle window open
        O = 10'h15A;
        begin
            int busy_low;
            busy_low = 0;
            for (int t = 0; t < 20; t++) begin
                I = I ^ 12'h001;
                for (int c = 0; c < 5; c++) begin
                    step(1);
                    if (!(t == 0 && c < 2) && !busy) busy_low++;
                end
            end
            chk("t2_busy_held", busy_low, 0);
        end
        sb.push_back({I, O});
        step(S - 3);
        chk("t2_valid_early", vec_valid, 0);
        chk("t2_busy", busy, 1);
        step(1);
        chk("t2_valid_rise", vec_valid, 1);
        step(S + 5);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_count", vec_count, 2);
        vec_ready = 1'b0;

        // Test 3: overflow with reader stalled
        do_reset();
        step(2);
        for (int i = 0; i < D + 2; i++) begin
            I = 12'h100 + 12'(i);
            if (i < D) sb.push_back({I, O});
            step(S + 6);
            if (i == D - 1) chk("t3_no_ovf_at_full", overflow, 0);
        end
        chk("t3_overflow", overflow, 1);
        chk("t3_count", vec_count, D + 2);
        chk("t3_valid", vec_valid, 1);
        chk("t3_head_stable", vec_data, {12'h100, O});
        drain("t3_drain");
        chk("t3_valid_after", vec_valid, 0);

        // Test 4: full FIFO, pop in the capture cycle
        do_reset();
        step(2);
        for (int i = 0; i < D; i++) begin
            I = 12'h200 + 12'(i);
            sb.push_back({I, O});
            step(S + 6);
        end
        I = 12'h2FF;
        sb.push_back({I, O});
        step(S + 2);
        vec_ready = 1'b1;
        step(1);
        vec_ready = 1'b0;
        step(2);
        chk("t4_overflow", overflow, 0);
        chk("t4_count", vec_count, D + 1);
        chk("t4_valid", vec_valid, 1);
        chk("t4_sb_left", sb.size(), D);
        drain("t4_drain");

        // Test 5: reset three cycles before capture
        do_reset();
        step(2);
        I = 12'h0A5;
        step(S + 6);
        chk("t5_valid_pre", vec_valid, 1);
        I = 12'h05A;
        step(S - 1);
        rst = 1'b1;
        I = '0;
        sb.delete();
        step(1);
        step(1);
        rst = 1'b0;
        chk("t5_valid_rst", vec_valid, 0);
        step(S + 6);
        chk("t5_valid", vec_valid, 0);
        chk("t5_count", vec_count, 0);
        chk("t5_busy", busy, 0);

        // Test 6: changes ignored while disabled
        vec_ready = 1'b1;
        en = 1'b0;
        I = 12'h3C3;
        step(5);
        I = 12'h3C4;
        step(S + 6);
        chk("t6_busy_dis", busy, 0);
        chk("t6_count_dis", vec_count, 0);
        en = 1'b1;
        step(S + 6);
        chk("t6_count_held", vec_count, 0);
        chk("t6_valid_held", vec_valid, 0);
        I = 12'h111;
        step(5);
        en = 1'b0;
        step(S + 3);
        chk("t6_abort_count", vec_count, 0);
        chk("t6_abort_busy", busy, 0);
        en = 1'b1;
        step(2);
        I = 12'h3C5;
        sb.push_back({I, O});
        step(S + 6);
        chk("t6_count", vec_count, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
